// File: rtl/io_pkg.sv
// Shared defaults, IRQ FSM state type and pointer-width helper for the I/O port controller.
package io_pkg;
  localparam int W_DEF     = 16;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} irq_state_t;

  // One extra MSB distinguishes full from empty when the index bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/io_fifo.sv
// Generic FIFO: push/pop qualified by the caller, head is 0 while empty; zero-latency head,
// no internal backpressure (caller gates push on full and pop on empty).
module io_fifo
  import io_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/io_port_ctrl.sv
// Processor I/O port controller: RX/TX FIFOs, sticky TX overflow, interrupt pulse FSM with hold-off.
// Optional IO_RX_IRQ_EN: RX empty->non-empty also raises an interrupt request.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int IRQ_HOLDOFF = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] in_port,
  input  logic         in_ack,
  input  logic [W-1:0] out_port,
  input  logic         out_strobe,
  output logic         interrupt,
  input  logic [W-1:0] ext_rx_data,
  input  logic         ext_rx_valid,
  output logic         ext_rx_ready,
  output logic [W-1:0] ext_tx_data,
  output logic         ext_tx_valid,
  input  logic         ext_tx_ready,
  input  logic         irq_req,
  output logic         rx_empty,
  output logic         tx_overflow
);
  localparam int CW = $clog2(IRQ_HOLDOFF + 1);

  logic rx_full, rx_push, rx_pop;
  logic tx_full, tx_empty, tx_push, tx_pop;
  logic req_now, pending;
  logic [CW-1:0] cnt;
  irq_state_t state;

  assign ext_rx_ready = !rx_full;
  assign rx_push      = ext_rx_valid && !rx_full;
  assign rx_pop       = in_ack && !rx_empty;
  assign tx_pop       = ext_tx_ready && !tx_empty;
  // The processor cannot stall: a full TX FIFO still accepts if it frees a slot this cycle.
  assign tx_push      = out_strobe && (!tx_full || tx_pop);
  assign ext_tx_valid = !tx_empty;

  io_fifo #(.W(W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(ext_rx_data),
    .head(in_port), .full(rx_full), .empty(rx_empty)
  );

  io_fifo #(.W(W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(out_port),
    .head(ext_tx_data), .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_overflow <= 1'b0;
    else if (out_strobe && !tx_push) tx_overflow <= 1'b1;
  end

`ifdef IO_RX_IRQ_EN
  assign req_now = irq_req | (rx_empty & rx_push);
`else
  assign req_now = irq_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      interrupt <= 1'b0;
      pending   <= 1'b0;
      cnt       <= '0;
    end else begin
      interrupt <= 1'b0;
      case (state)
        IDLE: begin
          if (pending || req_now) begin
            state     <= PULSE;
            interrupt <= 1'b1;
            pending   <= 1'b0;
          end
        end
        PULSE: begin
          state   <= HOLD;
          cnt     <= CW'(IRQ_HOLDOFF - 1);
          pending <= pending | req_now;
        end
        HOLD: begin
          // Serving a remembered request straight from HOLD keeps the pulse period at HOLDOFF+1.
          if (cnt == '0) begin
            if (pending || req_now) begin
              state     <= PULSE;
              interrupt <= 1'b1;
              pending   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt     <= cnt - CW'(1);
            pending <= pending | req_now;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
